// File: rtl/seven_seg_scanner.sv
// Time-multiplexed hex display driver: scans NUM_DIGITS digits, decodes 0-F and commits new values only at frame boundaries.
// Define SEG_LZ_SUPPRESS_EN to add leading-zero suppression of the committed value.
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned CLK_DIV        = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int unsigned PRE_W  = $clog2(CLK_DIV);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;

  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [PRE_W-1:0]      pre_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_W-1:0]     pend_digits_q;
  logic [NUM_DIGITS-1:0] pend_blank_q;
  logic [DATA_W-1:0]     disp_digits_q;
  logic [NUM_DIGITS-1:0] disp_blank_q;
  logic                  committed_q;

  logic                  tick_c;
  logic                  boundary_c;
  logic [NUM_DIGITS-1:0] lz_mask_c;
  logic [3:0]            cur_nib_c;
  logic                  cur_blank_c;
  logic [6:0]            seg_nxt_c;
  logic [NUM_DIGITS-1:0] dig_nxt_c;

  // Active-high segment pattern for one hex nibble (bit6=g .. bit0=a).
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h67;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick_c     = (pre_q == PRE_LAST);
  assign boundary_c = tick_c && (idx_q == IDX_LAST);

`ifdef SEG_LZ_SUPPRESS_EN
  logic lz_lead;

  // Blank zero digits from the top down until the first nonzero; digit 0 always shows.
  always_comb begin
    lz_mask_c = '0;
    lz_lead   = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      if (lz_lead && (disp_digits_q[4*i +: 4] == 4'h0)) lz_mask_c[i] = 1'b1;
      else                                              lz_lead      = 1'b0;
    end
  end
`else
  assign lz_mask_c = '0;
`endif

  // Next segment/enable values for the digit currently selected by idx_q.
  always_comb begin
    cur_nib_c   = 4'(disp_digits_q >> {idx_q, 2'b00});
    cur_blank_c = !committed_q || 1'(disp_blank_q >> idx_q) || 1'(lz_mask_c >> idx_q);
    seg_nxt_c   = (cur_blank_c ? 7'h00 : seg_decode(cur_nib_c)) ^ SEG_OFF;
    dig_nxt_c   = (NUM_DIGITS'(1) << idx_q) ^ DIG_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q         <= '0;
      idx_q         <= '0;
      pend_digits_q <= '0;
      pend_blank_q  <= '0;
      disp_digits_q <= '0;
      disp_blank_q  <= '0;
      committed_q   <= 1'b0;
      seg_out       <= SEG_OFF;
      dig_en        <= DIG_OFF;
      frame_done    <= 1'b0;
    end else begin
      pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);
      if (tick_c) idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

      if (load) begin
        pend_digits_q <= digits_in;
        pend_blank_q  <= blank_mask;
      end

      // A load on the boundary cycle bypasses pending so it lands in this frame.
      if (boundary_c) begin
        disp_digits_q <= load ? digits_in  : pend_digits_q;
        disp_blank_q  <= load ? blank_mask : pend_blank_q;
        committed_q   <= 1'b1;
      end

      seg_out    <= seg_nxt_c;
      dig_en     <= dig_nxt_c;
      frame_done <= boundary_c;
    end
  end

endmodule
